// File: rtl/fx_band_pkg.sv
// Shared widths, FSM encoding and sign-magnitude helper for the band power detector.
package fx_band_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned MAG_W  = 15;
   localparam int unsigned SQ_W   = 30;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DUMP  = 2'd2
   } state_t;

   // Drop the sign bit; negative zero naturally maps to magnitude 0.
   function automatic logic [MAG_W-1:0] sm_to_mag(input logic [DATA_W-1:0] x);
      return MAG_W'(x & DATA_W'({MAG_W{1'b1}}));
   endfunction

endpackage

// File: rtl/sm_square.sv
// Pipeline stages S1 (registered magnitude) and S2 (registered square) with a
// window-last tag carried alongside each sample.
module sm_square
   import fx_band_pkg::*;
(
   input  logic              clk_slow,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_last,
   input  logic [DATA_W-1:0] band_in,
   output logic              sq_valid,
   output logic              sq_last,
   output logic [MAG_W-1:0]  sq_mag,
   output logic [SQ_W-1:0]   sq_val
);

   logic             s1_valid;
   logic             s1_last;
   logic [MAG_W-1:0] s1_mag;

   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_mag   <= '0;
         sq_valid <= 1'b0;
         sq_last  <= 1'b0;
         sq_mag   <= '0;
         sq_val   <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         sq_valid <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mag  <= sm_to_mag(band_in);
            s1_last <= in_last;
         end
         sq_valid <= s1_valid;
         if (s1_valid) begin
            sq_val  <= SQ_W'(s1_mag) * SQ_W'(s1_mag);
            sq_mag  <= s1_mag;
            sq_last <= s1_last;
         end
      end
   end

endmodule

// File: rtl/band_power_detector.sv
// Windowed mean-square power and peak detector with hysteresis band flag.
// Results are staged when the last sample is accumulated and published one cycle later.
module band_power_detector
   import fx_band_pkg::*;
#(
   parameter int unsigned       WIN_LOG2  = 8,
   parameter logic [DATA_W-1:0] THRESH_HI = 16'h0100,
   parameter logic [DATA_W-1:0] THRESH_LO = 16'h0080
)
(
   input  logic              clk_slow,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] band_in,
   output logic [DATA_W-1:0] power_out,
   output logic [DATA_W-1:0] peak_out,
   output logic              power_valid,
   output logic              band_active
);

   localparam int unsigned         ACC_W     = SQ_W + WIN_LOG2;
   localparam int unsigned         PWR_SHIFT = WIN_LOG2 + SQ_W - DATA_W;
   localparam logic [WIN_LOG2-1:0] CNT_LAST  = '1;

   state_t              state_q;
   state_t              state_d;
   logic                commit_c;
   logic                accept_c;
   logic                window_done_c;
   logic [WIN_LOG2-1:0] cnt;
   logic                sq_valid;
   logic                sq_last;
   logic [MAG_W-1:0]    sq_mag;
   logic [SQ_W-1:0]     sq_val;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    sum_c;
   logic [MAG_W-1:0]    peak;
   logic [MAG_W-1:0]    max_c;
   logic [DATA_W-1:0]   res_power;
   logic [MAG_W-1:0]    res_peak;

   assign accept_c      = en & in_valid;
   assign window_done_c = en & sq_valid & sq_last;
   assign sum_c         = acc + ACC_W'(sq_val);
   assign max_c         = (sq_mag > peak) ? sq_mag : peak;

   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else if (accept_c) begin
         cnt <= cnt + WIN_LOG2'(1);
      end
   end

   sm_square u_sm_square (
      .clk_slow (clk_slow),
      .rst      (rst),
      .flush    (!en),
      .in_valid (accept_c),
      .in_last  (cnt == CNT_LAST),
      .band_in  (band_in),
      .sq_valid (sq_valid),
      .sq_last  (sq_last),
      .sq_mag   (sq_mag),
      .sq_val   (sq_val)
   );

   // S3: accumulate, or stage the finished window and restart from zero.
   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         acc       <= '0;
         peak      <= '0;
         res_power <= '0;
         res_peak  <= '0;
      end else if (!en) begin
         acc  <= '0;
         peak <= '0;
      end else if (sq_valid) begin
         if (sq_last) begin
            res_power <= DATA_W'(sum_c >> PWR_SHIFT);
            res_peak  <= max_c;
            acc       <= '0;
            peak      <= '0;
         end else begin
            acc  <= sum_c;
            peak <= max_c;
         end
      end
   end

   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_ACCUM;
            ST_ACCUM: if (window_done_c) state_d = ST_DUMP;
            ST_DUMP:  state_d = ST_ACCUM;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      commit_c = 1'b0;
      if (state_q == ST_DUMP && en) begin
         commit_c = 1'b1;
      end
   end

   // Publish staged results; band flag follows the new power with hysteresis.
   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         power_out   <= '0;
         peak_out    <= '0;
         power_valid <= 1'b0;
         band_active <= 1'b0;
      end else begin
         power_valid <= commit_c;
         if (commit_c) begin
            power_out <= res_power;
            peak_out  <= {1'b0, res_peak};
            if (res_power >= THRESH_HI) begin
               band_active <= 1'b1;
            end else if (res_power < THRESH_LO) begin
               band_active <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_band_power_detector.sv
// Self-checking bench: directed window table, corner sequences and a random run
// compared against a window-level reference model.
module tb_band_power_detector;

   localparam int unsigned WL = 2;
   localparam logic [15:0] HI = 16'd4;
   localparam logic [15:0] LO = 16'd2;

   logic        clk_slow = 1'b0;
   logic        rst;
   logic        en;
   logic        in_valid;
   logic [15:0] band_in;
   logic [15:0] power_out;
   logic [15:0] peak_out;
   logic        power_valid;
   logic        band_active;

   always #5 clk_slow = ~clk_slow;

   band_power_detector #(
      .WIN_LOG2  (WL),
      .THRESH_HI (HI),
      .THRESH_LO (LO)
   ) dut (
      .clk_slow    (clk_slow),
      .rst         (rst),
      .en          (en),
      .in_valid    (in_valid),
      .band_in     (band_in),
      .power_out   (power_out),
      .peak_out    (peak_out),
      .power_valid (power_valid),
      .band_active (band_active)
   );

   typedef struct {
      int          due;
      logic [15:0] pow;
      logic [15:0] peak;
   } pend_t;

   typedef struct {
      logic [15:0] data;
      logic [15:0] pow;
      logic [15:0] peak;
      logic        act;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_acc = 0;
   pend_t       pend[$];
   int          win[$];
   logic [15:0] m_pow = '0;
   logic [15:0] m_peak = '0;
   logic        m_act = 1'b0;
   logic        m_pv = 1'b0;
   vec_t        tbl[5];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the reference model and compare all outputs.
   task automatic step(input logic r, input logic e, input logic v, input logic [15:0] d);
      longint s;
      int     pk;
      pend_t  p;
      rst = r; en = e; in_valid = v; band_in = d;
      @(posedge clk_slow);
      #1;
      cyc++;
      m_pv = 1'b0;
      if (!r) begin
         win.delete(); pend.delete();
         m_pow = '0; m_peak = '0; m_act = 1'b0;
      end else if (!e) begin
         win.delete(); pend.delete();
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            m_pv = 1'b1; m_pow = p.pow; m_peak = p.peak;
            if (p.pow >= HI) m_act = 1'b1;
            else if (p.pow < LO) m_act = 1'b0;
         end
         if (v) begin
            win.push_back(int'(d & 16'h7FFF));
            last_acc = cyc;
            if (win.size() == (1 << WL)) begin
               s = 0; pk = 0;
               foreach (win[i]) begin
                  s += longint'(win[i]) * longint'(win[i]);
                  if (win[i] > pk) pk = win[i];
               end
               p.due = cyc + 3;
               p.pow = 16'((s >> WL) >> 14);
               p.peak = 16'(pk);
               pend.push_back(p);
               win.delete();
            end
         end
      end
      check("power_valid", 16'(power_valid), 16'(m_pv));
      check("power_out", power_out, m_pow);
      check("peak_out", peak_out, m_peak);
      check("band_active", 16'(band_active), 16'(m_act));
   endtask

   task automatic feed4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] d, input int gap);
      logic [15:0] s[4];
      s[0] = a; s[1] = b; s[2] = c; s[3] = d;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b1, 1'b1, s[k]);
         if (k < 3) repeat (gap) step(1'b1, 1'b1, 1'b0, 16'h0000);
      end
   endtask

   // Idle for a bounded number of cycles expecting exactly one pulse at latency 3.
   task automatic wait_pulse(input string name, input logic [15:0] p, input logic [15:0] pk,
                             input logic act);
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'h0000);
         if (power_valid) begin
            pulses++;
            check({name, "_latency"}, 16'(cyc - last_acc), 16'd3);
            check({name, "_power"}, power_out, p);
            check({name, "_peak"}, peak_out, pk);
            check({name, "_active"}, 16'(band_active), 16'(act));
         end
      end
      check({name, "_pulses"}, 16'(pulses), 16'd1);
   endtask

   initial begin
      tbl[0] = '{16'h0100, 16'h0004, 16'h0100, 1'b1};
      tbl[1] = '{16'h8000, 16'h0000, 16'h0000, 1'b0};
      tbl[2] = '{16'h7FFF, 16'hFFFC, 16'h7FFF, 1'b1};
      tbl[3] = '{16'h8100, 16'h0004, 16'h0100, 1'b1};
      tbl[4] = '{16'h8000, 16'h0000, 16'h0000, 1'b0};

      repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000);
      check("reset_power", power_out, 16'h0000);
      check("reset_peak", peak_out, 16'h0000);
      check("reset_active", 16'(band_active), 16'h0000);

      for (int t = 0; t < 5; t++) begin
         feed4(tbl[t].data, tbl[t].data, tbl[t].data, tbl[t].data, 0);
         wait_pulse($sformatf("tbl%0d", t), tbl[t].pow, tbl[t].peak, tbl[t].act);
      end

      // Back-to-back windows, no idle between them.
      feed4(16'h8100, 16'h8100, 16'h8100, 16'h8100, 0);
      feed4(16'h8000, 16'h8000, 16'h8000, 16'h8000, 0);
      wait_pulse("b2b_second", 16'h0000, 16'h0000, 1'b0);

      feed4(16'h0100, 16'h0100, 16'h0100, 16'h0100, 2);
      wait_pulse("gapped", 16'h0004, 16'h0100, 1'b1);

      feed4(16'h0100, 16'h0100, 16'h0100, 16'h0000, 0);
      wait_pulse("hyst_hold", 16'h0003, 16'h0100, 1'b1);
      feed4(16'h8100, 16'h0000, 16'h0000, 16'h8000, 0);
      wait_pulse("hyst_clear", 16'h0001, 16'h0100, 1'b0);

      // Enable drop mid-window: partial window discarded, outputs hold.
      step(1'b1, 1'b1, 1'b1, 16'h7FFF);
      step(1'b1, 1'b1, 1'b1, 16'h7FFF);
      repeat (5) step(1'b1, 1'b0, 1'b0, 16'h0000);
      check("endrop_power", power_out, 16'h0001);
      check("endrop_peak", peak_out, 16'h0100);
      check("endrop_active", 16'(band_active), 16'h0000);
      feed4(16'h0100, 16'h0100, 16'h0100, 16'h0100, 0);
      wait_pulse("fresh_window", 16'h0004, 16'h0100, 1'b1);

      // Enable drop with a completed window still in flight.
      feed4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0000);
      check("inflight_power", power_out, 16'h0004);

      // Reset mid-window.
      step(1'b1, 1'b1, 1'b1, 16'h0100);
      step(1'b1, 1'b1, 1'b1, 16'h0100);
      step(1'b1, 1'b1, 1'b1, 16'h0100);
      step(1'b0, 1'b1, 1'b1, 16'h0100);
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      repeat (6) step(1'b1, 1'b1, 1'b0, 16'h0000);
      check("midreset_power", power_out, 16'h0000);
      check("midreset_peak", peak_out, 16'h0000);
      check("midreset_active", 16'(band_active), 16'h0000);

      for (int n = 0; n < 600; n++) begin
         logic [15:0] d;
         if ($urandom_range(0, 3) == 0) d = 16'($urandom);
         else d = {1'($urandom_range(0, 1)), 6'h00, 9'($urandom_range(0, 511))};
         step(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 24) != 0),
              1'($urandom_range(0, 1)), d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/band_power_detector.md
BAND_POWER_DETECTOR -- requirements
Module: band_power_detector

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 8, log2 of window length in samples (legal 1..8).
REQ-002 SHALL have parameter THRESH_HI, default 16'h0100, power level at or above which band_active sets.
REQ-003 SHALL have parameter THRESH_LO, default 16'h0080, power level below which band_active clears (THRESH_LO <= THRESH_HI).
REQ-004 SHALL have port clk_slow  input  1  sample clock, the block's only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port en  input  1  detector enable; low holds the block idle.
REQ-007 SHALL have port in_valid  input  1  band_in holds a new filtered sample this cycle.
REQ-008 SHALL have port band_in  input  16  band-filter output, sign-magnitude (bit15 sign, bits14:0 magnitude).
REQ-009 SHALL have port power_out  output  16  unsigned mean-square power of the last completed window.
REQ-010 SHALL have port peak_out  output  16  largest magnitude in the last completed window, bit15 always 0.
REQ-011 SHALL have port power_valid  output  1  one-cycle pulse: power_out/peak_out just updated.
REQ-012 SHALL have port band_active  output  1  hysteresis detection flag for the band.

Function
REQ-013 SHALL accept a sample only on a rising edge with en=1 and in_valid=1; cycles with in_valid=0 SHALL not advance any state.
REQ-014 SHALL take magnitude as band_in[14:0], ignoring sign; 16'h8000 (negative zero) SHALL count as magnitude 0.
REQ-015 SHALL run a 3-stage pipeline: S1 registers magnitude, S2 registers 30-bit magnitude square, S3 adds square into a (30+WIN_LOG2)-bit accumulator; no overflow is possible and no saturation SHALL be applied.
REQ-016 SHALL count accepted samples with a WIN_LOG2-bit counter that wraps from 2^WIN_LOG2-1 to 0.
REQ-017 SHALL run FSM IDLE -> ACCUM on en=1; ACCUM -> DUMP when the window's last sample reaches S3; DUMP -> ACCUM next cycle (or IDLE if en=0); any state -> IDLE when en=0.
REQ-018 SHALL, on the last sample of a window, write power_out = ((acc + square) >> WIN_LOG2)[29:14] and peak_out = window max magnitude, clearing acc and peak for the next window in the same edge.
REQ-019 SHALL assert power_valid for exactly one cycle, 3 clk_slow edges after the edge that accepted the window's last sample (fixed latency 3).
REQ-020 SHALL keep accepting samples during DUMP; a sample accepted in the last-sample edge's successor SHALL belong to the next window, no samples dropped at back-to-back in_valid.
REQ-021 SHALL, in the same edge that updates power_out, set band_active if new power_out >= THRESH_HI, clear it if new power_out < THRESH_LO, else hold it.
REQ-022 SHALL, when en falls mid-window, discard the partial window and in-flight pipeline data, clear counter/acc/peak, issue no power_valid, and hold power_out, peak_out, band_active.
REQ-023 SHALL start a fresh window at counter 0 on the first accepted sample after en rises.

Reset
REQ-024 SHALL, on rising edge with rst=0, set FSM to IDLE and clear counter, accumulator, peak, pipeline registers and valids.
REQ-025 SHALL drive power_out=16'h0000, peak_out=16'h0000, power_valid=0, band_active=0 from reset until the first completed window.
REQ-026 SHALL give reset priority over en and in_valid; reset mid-window discards the window with no power_valid.

Structure
REQ-027 SHALL place data width (16), magnitude width (15), square width (30), FSM state encoding and a sign-magnitude-to-magnitude function in shared package fx_band_pkg.
REQ-028 SHALL use one sub-module, sm_square, holding registered magnitude extraction and squaring (pipeline stages S1-S2).

Verification (bench uses WIN_LOG2=2, THRESH_HI=4, THRESH_LO=2)
REQ-029 SHALL check: 4 consecutive samples 16'h0100 -> power_valid pulse 3 cycles after 4th sample, power_out=16'h0004, peak_out=16'h0100, band_active=1.
REQ-030 SHALL check: 4 samples 16'h8100 then 4 samples 16'h8000 -> first power_out=4; second power_out=0, peak_out=0, band_active clears.
REQ-031 SHALL check: 4 samples 16'h7FFF -> power_out=16'hFFFC (65532), peak_out=16'h7FFF.
REQ-032 SHALL check: 4 samples 16'h0100 with in_valid low for 2 cycles between each -> same result as REQ-029, one power_valid only.
REQ-033 SHALL check: windows giving power 4, 3, 1 -> band_active 1, 1 (hold), 0.
REQ-034 SHALL check: en dropped after 2 samples, then reset asserted mid-window on a later run -> no power_valid either time, outputs hold then read 0 after reset.
